route_lock_controller: RTL and testbench
========================================

# route_lock_controller

Per-input-port wormhole route controller for a router node. It accepts flits from one input buffer and hands each head flit to the node's head-flit decoder. It latches the returned output-port request and holds that request towards the switch allocator until granted. It then streams the packet's body and tail flits to the crossbar through a one-flit pipeline register, and releases the route lock after the tail flit leaves. One instance sits between each input FIFO and the crossbar/allocator.

## Interface
Parameters:
- `N`, 4: number of nodes in the network; passed through to the decoder.
- `INDEX`, 1: index of this node.
- `DATA_WIDTH`, 8: phit width in bits.
- `PhitPerFlit`, 2: phits per flit. Flit width `FW = PhitPerFlit*DATA_WIDTH`.
- `REQUEST_WIDTH`, 2: width of the output-port request code.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_flit`  in  FW  flit from the input buffer. `in_flit[FW-1:FW-2]` is the flit type: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet).
- `in_valid`  in  1  `in_flit` is valid.
- `in_ready`  out  1  controller accepts `in_flit` this cycle.
- `dec_flit`  out  FW  latched head flit, driven to the decoder's `HeadFlit` input.
- `dec_request`  in  REQUEST_WIDTH  the decoder's combinational `RequestMessage`.
- `req_valid`  out  1  route request / route lock towards the allocator.
- `req_port`  out  REQUEST_WIDTH  requested output port. Code 0 means local eject.
- `grant`  in  1  allocator grants `req_port` to this input.
- `out_flit`  out  FW  flit to the crossbar.
- `out_valid`  out  1  `out_flit` is valid.
- `out_ready`  in  1  the downstream side accepts `out_flit`.
- `drop_count`  out  8  saturating count of non-head flits received while IDLE.

## Operation
- States: IDLE, ROUTE, REQUEST, FORWARD.
- Storage: flit buffer `buf` + `buf_valid`; register `tail_in` (tail already accepted); `req_port`; `dec_flit` register.

IDLE:
- `in_ready`=1.
- On `in_valid` with type 01 or 11: load `dec_flit`, load `buf`, set `buf_valid`=1. Set `tail_in`=1 if the type is 11, else 0. Go to ROUTE.
- On `in_valid` with type 00 or 10: discard the flit, increment `drop_count` (saturating at 255), stay in IDLE.

ROUTE:
- `in_ready`=0.
- Register `req_port` <= `dec_request`.
- Go to REQUEST.

REQUEST:
- `req_valid`=1, `in_ready`=0.
- On `grant`=1, go to FORWARD. Otherwise hold, with no timeout.

FORWARD:
- `req_valid` stays 1 (lock held). `grant` is ignored.
- `out_valid`=`buf_valid`; `out_flit`=`buf`.
- `in_ready` = !`tail_in` && (!`buf_valid` || `out_ready`).
- On an accepted input: load `buf`. Set `tail_in` if its type is 10 or 11. A head-type flit arriving mid-packet is forwarded as data; there is no check.
- When `out_valid && out_ready` and `tail_in` and no flit is loaded in the same cycle: clear `buf_valid` and `tail_in`, go to IDLE.

Other rules:
- `req_port`, `dec_flit` and `drop_count` hold their values between packets.
- Reset, whether idle or mid-packet: state=IDLE, `buf_valid`=0, `tail_in`=0, `req_port`=0, `dec_flit`=0, `drop_count`=0. A packet in flight is abandoned.
- Reset values of the outputs: `in_ready`=1 (IDLE), `req_valid`=0, `out_valid`=0, `out_flit`=0.

## Timing
- Head flit accepted at edge t. ROUTE during cycle t+1. `req_valid`=1 from cycle t+2.
- `grant` sampled at edge t+2 at the earliest. FORWARD begins cycle t+3, with the head flit on `out_flit`/`out_valid` in that cycle.
- Steady state is 1 flit/cycle: the input is accepted while the buffer drains in the same cycle.
- Flit latency through FORWARD is 1 cycle.
- `req_valid` falls in the cycle after the tail flit's `out_valid && out_ready`. A new head can be accepted in that same cycle, since the block is then in IDLE.
- Minimum packet-to-packet gap on the input: 3 cycles (ROUTE, REQUEST, first FORWARD cycle).
- `dec_request` must settle within one cycle of `dec_flit` changing.

## Test plan
- Single-flit packet, type 11, destination 3, `dec_request`=2, `grant` in cycle t+2, `out_ready`=1 -> `out_flit` equals the input at t+3, `req_port`=2, `req_valid` high for t+2..t+3 and low at t+4.
- 4-flit packet (head, 2 body, tail) with `out_ready`=1 throughout -> the four flits appear on consecutive cycles t+3..t+6 in order, `in_ready`=0 after the tail is accepted, state returns to IDLE at t+7.
- `grant` withheld for 10 cycles -> `req_valid` stays 1, `out_valid`=0, `in_ready`=0 throughout; forwarding starts the cycle after `grant`.
- `out_ready` toggling 1,0,0,1 during the body -> no flit lost or duplicated; `in_ready` tracks the buffer-full rule.
- 300 body flits presented in IDLE -> all dropped, `drop_count`=255, no `req_valid`.
- `rst` asserted in FORWARD after 2 of 4 flits -> next cycle IDLE, `out_valid`=0, `req_valid`=0, `drop_count`=0; a new head is accepted normally.

Source files
------------

// File: rtl/route_lock_controller.sv
// route_lock_controller
// Wormhole route controller for one router input port. A head flit is handed
// to the head-flit decoder, the returned output-port request is latched and
// held towards the switch allocator until granted. The rest of the packet then
// streams to the crossbar through a one-flit register. The lock is released
// once the tail flit has left.
module route_lock_controller #(
   parameter int N             = 4,
   parameter int INDEX         = 1,
   parameter int DATA_WIDTH    = 8,
   parameter int PhitPerFlit   = 2,
   parameter int REQUEST_WIDTH = 2,
   localparam int FW           = PhitPerFlit * DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [FW-1:0]            in_flit,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [FW-1:0]            dec_flit,
   input  logic [REQUEST_WIDTH-1:0] dec_request,
   output logic                     req_valid,
   output logic [REQUEST_WIDTH-1:0] req_port,
   input  logic                     grant,
   output logic [FW-1:0]            out_flit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               drop_count
);

   // The node parameters only matter to the decoder; reject nonsense early.
   generate
      if (N < 2 || INDEX < 0 || INDEX >= N || FW < 2) begin : g_bad_params
         $error("route_lock_controller: invalid N/INDEX/flit width");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROUTE   = 2'd1,
      REQUEST = 2'd2,
      FORWARD = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [FW-1:0]            r_buf;
   logic                     r_buf_valid;
   logic                     r_tail_in;
   logic [REQUEST_WIDTH-1:0] r_req_port;
   logic [FW-1:0]            r_dec_flit;
   logic [7:0]               r_drop_count;

   logic                     w_in_ready;
   logic                     w_req_valid;
   logic                     w_out_valid;
   logic                     w_accept;
   logic                     w_drain;
   logic                     w_in_is_head;
   logic                     w_in_is_tail;

   // Flit type lives in the top two bits: bit FW-2 set means a head (01/11),
   // bit FW-1 set means the packet ends with this flit (10/11).
   assign w_in_is_head = in_flit[FW-2];
   assign w_in_is_tail = in_flit[FW-1];
   assign w_accept     = in_valid && w_in_ready;
   assign w_drain      = w_out_valid && out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_req_valid  = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid && w_in_is_head) begin
               w_state_next = ROUTE;
            end
         end
         ROUTE: begin
            w_state_next = REQUEST;
         end
         REQUEST: begin
            w_req_valid = 1'b1;
            if (grant) begin
               w_state_next = FORWARD;
            end
         end
         FORWARD: begin
            // Lock stays asserted for the whole packet; grant is ignored here.
            w_req_valid = 1'b1;
            w_out_valid = r_buf_valid;
            // Buffer can take a new flit if empty or draining this cycle,
            // but never after the tail has been taken in.
            w_in_ready  = !r_tail_in && (!r_buf_valid || out_ready);
            if (r_buf_valid && out_ready && r_tail_in) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Flit buffer, head latch, request latch and drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf        <= '0;
         r_buf_valid  <= 1'b0;
         r_tail_in    <= 1'b0;
         r_req_port   <= '0;
         r_dec_flit   <= '0;
         r_drop_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_in_is_head) begin
                     r_dec_flit  <= in_flit;
                     r_buf       <= in_flit;
                     r_buf_valid <= 1'b1;
                     r_tail_in   <= w_in_is_tail;
                  end else if (r_drop_count != 8'hFF) begin
                     r_drop_count <= r_drop_count + 8'd1;
                  end
               end
            end
            ROUTE: begin
               // Decoder has had a full cycle to settle on r_dec_flit.
               r_req_port <= dec_request;
            end
            FORWARD: begin
               if (w_accept) begin
                  r_buf       <= in_flit;
                  r_buf_valid <= 1'b1;
                  r_tail_in   <= w_in_is_tail;
               end else if (w_drain) begin
                  r_buf_valid <= 1'b0;
                  r_tail_in   <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output drive; out_flit is zero whenever nothing valid is presented.
   assign in_ready   = w_in_ready;
   assign req_valid  = w_req_valid;
   assign req_port   = r_req_port;
   assign dec_flit   = r_dec_flit;
   assign out_valid  = w_out_valid;
   assign out_flit   = w_out_valid ? r_buf : '0;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_route_lock_controller.sv
// Directed testbench for route_lock_controller.
// Each "cycle" below begins 1 time unit after a rising edge; inputs are set,
// then outputs are sampled 1 more unit later, well away from the edge.
module tb_route_lock_controller;

   localparam int N             = 4;
   localparam int INDEX         = 1;
   localparam int DATA_WIDTH    = 8;
   localparam int PhitPerFlit   = 2;
   localparam int REQUEST_WIDTH = 2;
   localparam int FW            = PhitPerFlit * DATA_WIDTH;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [FW-1:0]            in_flit;
   logic                     in_valid;
   logic                     in_ready;
   logic [FW-1:0]            dec_flit;
   logic [REQUEST_WIDTH-1:0] dec_request;
   logic                     req_valid;
   logic [REQUEST_WIDTH-1:0] req_port;
   logic                     grant;
   logic [FW-1:0]            out_flit;
   logic                     out_valid;
   logic                     out_ready;
   logic [7:0]               drop_count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // Stand-in head-flit decoder: destination in the low two bits.
   // Own node -> 0 (eject), higher index -> 2, lower index -> 1.
   always_comb begin
      if (dec_flit[1:0] == 2'(INDEX))      dec_request = 2'd0;
      else if (dec_flit[1:0] > 2'(INDEX))  dec_request = 2'd2;
      else                                 dec_request = 2'd1;
   end

   route_lock_controller #(
      .N(N), .INDEX(INDEX), .DATA_WIDTH(DATA_WIDTH),
      .PhitPerFlit(PhitPerFlit), .REQUEST_WIDTH(REQUEST_WIDTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .dec_flit(dec_flit), .dec_request(dec_request),
      .req_valid(req_valid), .req_port(req_port), .grant(grant),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
      .drop_count(drop_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_flit = '0; in_valid = 1'b0; grant = 1'b0; out_ready = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      $display("reset: in_ready=%0b req_valid=%0b out_valid=%0b", in_ready, req_valid, out_valid);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_flit", 32'(out_flit), 0);
      chk("rst_drop", 32'(drop_count), 0);

      // ---- single-flit packet, type 11, destination 3 ----
      cyc();                                   // t
      in_flit = 16'hC003; in_valid = 1'b1; #1;
      chk("sf_in_ready_t", 32'(in_ready), 1);
      cyc(); in_valid = 1'b0; #1;               // t+1 ROUTE
      chk("sf_in_ready_t1", 32'(in_ready), 0);
      chk("sf_req_valid_t1", 32'(req_valid), 0);
      chk("sf_dec_flit", 32'(dec_flit), 32'hC003);
      cyc(); grant = 1'b1; #1;                  // t+2 REQUEST
      chk("sf_req_valid_t2", 32'(req_valid), 1);
      chk("sf_req_port", 32'(req_port), 2);
      chk("sf_out_valid_t2", 32'(out_valid), 0);
      cyc(); grant = 1'b0; #1;                  // t+3 FORWARD
      $display("single: out_flit=%h out_valid=%0b req_valid=%0b", out_flit, out_valid, req_valid);
      chk("sf_out_valid_t3", 32'(out_valid), 1);
      chk("sf_out_flit_t3", 32'(out_flit), 32'hC003);
      chk("sf_req_valid_t3", 32'(req_valid), 1);
      cyc(); #1;                                // t+4 IDLE
      chk("sf_req_valid_t4", 32'(req_valid), 0);
      chk("sf_out_valid_t4", 32'(out_valid), 0);
      chk("sf_in_ready_t4", 32'(in_ready), 1);

      // ---- 4-flit packet, destination 0 ----
      in_flit = 16'h4000; in_valid = 1'b1; #1;  // t
      chk("mf_in_ready_t", 32'(in_ready), 1);
      cyc(); in_valid = 1'b0; #1;               // t+1
      cyc(); grant = 1'b1; #1;                  // t+2
      chk("mf_req_port", 32'(req_port), 1);
      cyc(); grant = 1'b0; in_flit = 16'h0011; in_valid = 1'b1; #1;  // t+3
      chk("mf_out_t3", 32'(out_flit), 32'h4000);
      chk("mf_in_ready_t3", 32'(in_ready), 1);
      cyc(); in_flit = 16'h0022; #1;            // t+4
      chk("mf_out_t4", 32'(out_flit), 32'h0011);
      cyc(); in_flit = 16'h8033; #1;            // t+5
      chk("mf_out_t5", 32'(out_flit), 32'h0022);
      chk("mf_in_ready_t5", 32'(in_ready), 1);
      cyc(); in_valid = 1'b0; #1;               // t+6
      $display("multi: tail out_flit=%h in_ready=%0b", out_flit, in_ready);
      chk("mf_out_t6", 32'(out_flit), 32'h8033);
      chk("mf_out_valid_t6", 32'(out_valid), 1);
      chk("mf_in_ready_t6", 32'(in_ready), 0);
      cyc(); #1;                                // t+7 IDLE
      chk("mf_req_valid_t7", 32'(req_valid), 0);
      chk("mf_in_ready_t7", 32'(in_ready), 1);

      // ---- grant withheld 10 cycles, then out_ready 1,0,0,1 ----
      in_flit = 16'h4003; in_valid = 1'b1; #1;
      cyc(); in_valid = 1'b0; #1;               // ROUTE
      for (int i = 0; i < 10; i++) begin
         cyc(); #1;                             // REQUEST, no grant
         chk("gw_req_valid", 32'(req_valid), 1);
         chk("gw_out_valid", 32'(out_valid), 0);
         chk("gw_in_ready", 32'(in_ready), 0);
      end
      grant = 1'b1;
      cyc(); grant = 1'b0; out_ready = 1'b1; in_flit = 16'h00A1; in_valid = 1'b1; #1;  // F0
      $display("grant late: out_flit=%h out_valid=%0b", out_flit, out_valid);
      chk("gw_out_f0", 32'(out_flit), 32'h4003);
      chk("gw_out_valid_f0", 32'(out_valid), 1);
      chk("tg_in_ready_f0", 32'(in_ready), 1);
      cyc(); out_ready = 1'b0; in_flit = 16'h00B2; #1;                  // F1
      chk("tg_out_f1", 32'(out_flit), 32'h00A1);
      chk("tg_in_ready_f1", 32'(in_ready), 0);
      cyc(); #1;                                                        // F2
      chk("tg_out_f2", 32'(out_flit), 32'h00A1);
      chk("tg_out_valid_f2", 32'(out_valid), 1);
      chk("tg_in_ready_f2", 32'(in_ready), 0);
      cyc(); out_ready = 1'b1; #1;                                      // F3
      chk("tg_out_f3", 32'(out_flit), 32'h00A1);
      chk("tg_in_ready_f3", 32'(in_ready), 1);
      cyc(); in_flit = 16'h80C3; #1;                                    // F4
      chk("tg_out_f4", 32'(out_flit), 32'h00B2);
      cyc(); in_valid = 1'b0; #1;                                       // F5
      chk("tg_out_f5", 32'(out_flit), 32'h80C3);
      chk("tg_in_ready_f5", 32'(in_ready), 0);
      cyc(); #1;                                                        // F6 IDLE
      chk("tg_req_valid_f6", 32'(req_valid), 0);

      // ---- 300 non-head flits in IDLE ----
      for (int i = 0; i < 300; i++) begin
         in_flit = (i % 2 == 1) ? (16'h8000 | 16'(i)) : 16'(i);
         in_valid = 1'b1; #1;
         chk("dr_req_valid", 32'(req_valid), 0);
         cyc();
         if (i == 99) chk("dr_count_100", 32'(drop_count), 100);
      end
      in_valid = 1'b0; #1;
      $display("drops: drop_count=%0d", drop_count);
      chk("dr_count_sat", 32'(drop_count), 255);
      chk("dr_in_ready", 32'(in_ready), 1);

      // ---- reset mid-packet, then a fresh packet ----
      cyc(); in_flit = 16'h4001; in_valid = 1'b1; #1;
      cyc(); in_valid = 1'b0; #1;               // ROUTE
      cyc(); grant = 1'b1; #1;                  // REQUEST
      chk("rm_req_port", 32'(req_port), 0);
      cyc(); grant = 1'b0; in_flit = 16'h0044; in_valid = 1'b1; #1;  // F0
      chk("rm_out_f0", 32'(out_flit), 32'h4001);
      cyc(); in_valid = 1'b0; rst = 1'b1; #1;   // F1
      chk("rm_out_f1", 32'(out_flit), 32'h0044);
      cyc(); rst = 1'b0; #1;
      $display("mid reset: out_valid=%0b req_valid=%0b drop=%0d", out_valid, req_valid, drop_count);
      chk("rm_out_valid", 32'(out_valid), 0);
      chk("rm_req_valid", 32'(req_valid), 0);
      chk("rm_drop", 32'(drop_count), 0);
      chk("rm_in_ready", 32'(in_ready), 1);
      chk("rm_dec_flit", 32'(dec_flit), 0);
      chk("rm_out_flit", 32'(out_flit), 0);
      in_flit = 16'hC002; in_valid = 1'b1; #1;
      cyc(); in_valid = 1'b0; #1;
      cyc(); grant = 1'b1; #1;
      chk("rm2_req_port", 32'(req_port), 2);
      chk("rm2_req_valid", 32'(req_valid), 1);
      cyc(); grant = 1'b0; #1;
      chk("rm2_out", 32'(out_flit), 32'hC002);
      cyc(); #1;
      chk("rm2_req_valid_end", 32'(req_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
